// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side deframer.
// The stage buffer depth is fixed at three entries.
package fifo_rd_pkg;

  typedef enum logic {HDR, PAYLOAD} deframe_state_t;

  localparam int unsigned BUF_DEPTH = 3;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned PTR_W     = 2;

  // Modulo-BUF_DEPTH pointer increment.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/rd_stage_buf.sv
// Three-entry synchronous stage buffer that soaks up the FIFO read latency.
// The head entry stays stable until it is popped.
module rd_stage_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [1:0]       occ_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (occ_q != 2'(BUF_DEPTH));
  assign do_pop  = pop_i && (occ_q != 2'd0);

  always_comb begin
    occ_d = occ_q;
    unique case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      occ_q <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_deframer.sv
// Read-side FIFO consumer: splits the word stream into length-prefixed frames
// and streams the payload out on valid/ready with a last-beat flag.
module fifo_rd_deframer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned fifo_width = 8,
  parameter int unsigned cnt_width  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [fifo_width-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [fifo_width-1:0] m_data,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  zero_len,
  output logic [cnt_width-1:0]  frame_cnt,
  output logic                  busy
);

  deframe_state_t        state_q;
  logic                  en_q;
  logic                  inflight_q;
  logic [LEN_W-1:0]      remaining_q;
  logic [cnt_width-1:0]  frame_cnt_q;
  logic                  frame_done_q;
  logic                  zero_len_q;

  logic [1:0]            occ;
  logic [fifo_width-1:0] head;
  logic                  hdr_pop;
  logic                  beat_hs;
  logic                  pop;

  // en_q keeps the read enable low while reset is held and for one cycle after.
  always_comb begin
    fifo_r_en = en_q && !fifo_empty && (({1'b0, occ} + {2'b00, inflight_q}) < 3'd3);
    m_valid   = (state_q == PAYLOAD) && (occ != 2'd0);
    m_data    = head;
    m_last    = m_valid && (remaining_q == LEN_W'(1));
    beat_hs   = m_valid && m_ready;
    hdr_pop   = (state_q == HDR) && (occ != 2'd0);
    pop       = hdr_pop || beat_hs;
  end

  rd_stage_buf #(
    .Width (fifo_width)
  ) u_buf (
    .clk_i   (rd_clk),
    .rst_ni  (rd_rst_n),
    .push_i  (inflight_q),
    .wdata_i (fifo_data),
    .pop_i   (pop),
    .occ_o   (occ),
    .head_o  (head)
  );

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q      <= HDR;
      en_q         <= 1'b0;
      inflight_q   <= 1'b0;
      remaining_q  <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      zero_len_q   <= 1'b0;
    end else begin
      en_q         <= 1'b1;
      inflight_q   <= fifo_r_en;
      frame_done_q <= 1'b0;
      zero_len_q   <= 1'b0;
      unique case (state_q)
        HDR: begin
          if (hdr_pop) begin
            remaining_q <= head[LEN_W-1:0];
            if (head[LEN_W-1:0] != '0) begin
              state_q <= PAYLOAD;
            end else begin
              zero_len_q <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (beat_hs) begin
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == LEN_W'(1)) begin
              state_q      <= HDR;
              frame_cnt_q  <= frame_cnt_q + 1'b1;
              frame_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= HDR;
      endcase
    end
  end

  assign frame_done = frame_done_q;
  assign zero_len   = zero_len_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q == PAYLOAD);

endmodule

// File: tb/tb_fifo_rd_deframer.sv
// Directed bench for fifo_rd_deframer with a behavioural FIFO read-port model
// and a beat monitor; a small counter width keeps the wrap test short.
module tb_fifo_rd_deframer;

  localparam int unsigned FW = 12;
  localparam int unsigned CW = 8;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b0;
  logic          fifo_empty;
  logic          fifo_r_en;
  logic [FW-1:0] fifo_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [FW-1:0] m_data;
  logic          m_last;
  logic          frame_done;
  logic          zero_len;
  logic [CW-1:0] frame_cnt;
  logic          busy;

  logic [FW-1:0] mem [0:4095];
  int            wr_cnt = 0;
  int            rd_idx = 0;
  bit            flush_on_rst = 1'b0;

  logic [FW:0]   beat_q [$];
  int            done_cnt = 0;
  int            zl_cnt = 0;
  int            n_chk = 0;
  int            n_err = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_deframer #(
    .fifo_width (FW),
    .cnt_width  (CW)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_rst_n   (rd_rst_n),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .frame_done (frame_done),
    .zero_len   (zero_len),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  // FIFO read port with registered data; a read-domain reset may flush it.
  assign fifo_empty = (rd_idx >= wr_cnt);

  always @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      if (flush_on_rst) rd_idx <= wr_cnt;
      fifo_data <= '0;
    end else if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  // Handshake seen at the negedge completes on the following posedge.
  always @(negedge rd_clk) begin
    if (m_valid && m_ready) beat_q.push_back({m_last, m_data});
    if (frame_done) done_cnt <= done_cnt + 1;
    if (zero_len) zl_cnt <= zl_cnt + 1;
  end

  task automatic push(input logic [FW-1:0] w);
    mem[wr_cnt] = w;
    wr_cnt++;
  endtask

  task automatic tick();
    @(negedge rd_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [FW:0] exp);
    logic [FW:0] g;
    g = 'x;
    if (idx < beat_q.size()) g = beat_q[idx];
    check(tag, 32'(g), 32'(exp));
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (beat_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(beat_q.size() >= n), 32'd1);
  endtask

  initial begin
    int base;
    int d0;
    int z0;

    // Reset: first frame already waiting in the FIFO, header upper bits set.
    push(12'hF03); push(12'hA01); push(12'hA02); push(12'hA03);
    repeat (3) tick();
    check("rst_ren", 32'(fifo_r_en), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_zl", 32'(zero_len), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    m_ready = 1'b1;
    @(posedge rd_clk); #1;
    rd_rst_n = 1'b1;

    // Frame 1: latency and back-to-back beats.
    tick();
    tick();
    check("t1_ren_c0", 32'(fifo_r_en), 32'd1);
    check("t1_nv_c0", 32'(m_valid), 32'd0);
    tick(); check("t1_nv_c1", 32'(m_valid), 32'd0);
    tick(); check("t1_nv_c2", 32'(m_valid), 32'd0);
    tick();
    check("t1_v_c3", 32'(m_valid), 32'd1);
    check("t1_d_c3", 32'(m_data), 32'h A01);
    check("t1_l_c3", 32'(m_last), 32'd0);
    tick();
    check("t1_v_c4", 32'(m_valid), 32'd1);
    check("t1_d_c4", 32'(m_data), 32'h A02);
    check("t1_l_c4", 32'(m_last), 32'd0);
    tick();
    check("t1_d_c5", 32'(m_data), 32'h A03);
    check("t1_l_c5", 32'(m_last), 32'd1);
    check("t1_busy_c5", 32'(busy), 32'd1);
    tick();
    check("t1_nv_c6", 32'(m_valid), 32'd0);
    check("t1_done_c6", 32'(frame_done), 32'd1);
    check("t1_cnt", 32'(frame_cnt), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    tick();
    check("t1_done_c7", 32'(frame_done), 32'd0);
    check("t1_nbeats", 32'(beat_q.size()), 32'd3);
    check("t1_dones", 32'(done_cnt), 32'd1);

    // Zero-length frame followed by a single-beat frame.
    base = beat_q.size(); z0 = zl_cnt; d0 = done_cnt;
    push(12'h000); push(12'h001); push(12'h055);
    wait_beats(base + 1, 20, "t2_wait");
    repeat (4) tick();
    check("t2_zl", 32'(zl_cnt - z0), 32'd1);
    check("t2_nbeats", 32'(beat_q.size() - base), 32'd1);
    check_beat("t2_b0", base, {1'b1, 12'h055});
    check("t2_dones", 32'(done_cnt - d0), 32'd1);
    check("t2_cnt", 32'(frame_cnt), 32'd2);

    // Backpressure mid-frame with more data queued behind it.
    base = beat_q.size();
    push(12'h004); push(12'hB01); push(12'hB02); push(12'hB03); push(12'hB04);
    push(12'h002); push(12'hC01); push(12'hC02);
    wait_beats(base + 1, 20, "t3_wait1");
    @(posedge rd_clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3_stall_v%0d", i), 32'(m_valid), 32'd1);
      check($sformatf("t3_stall_d%0d", i), 32'(m_data), 32'h B02);
      check($sformatf("t3_stall_l%0d", i), 32'(m_last), 32'd0);
      if (i >= 2) check($sformatf("t3_stall_ren%0d", i), 32'(fifo_r_en), 32'd0);
    end
    @(posedge rd_clk); #1;
    m_ready = 1'b1;
    wait_beats(base + 6, 30, "t3_wait2");
    repeat (3) tick();
    check("t3_nbeats", 32'(beat_q.size() - base), 32'd6);
    check_beat("t3_b0", base + 0, {1'b0, 12'hB01});
    check_beat("t3_b1", base + 1, {1'b0, 12'hB02});
    check_beat("t3_b2", base + 2, {1'b0, 12'hB03});
    check_beat("t3_b3", base + 3, {1'b1, 12'hB04});
    check_beat("t3_b4", base + 4, {1'b0, 12'hC01});
    check_beat("t3_b5", base + 5, {1'b1, 12'hC02});
    check("t3_cnt", 32'(frame_cnt), 32'd4);

    // FIFO runs dry between payload words 2 and 3.
    base = beat_q.size();
    push(12'h005); push(12'hD01); push(12'hD02);
    wait_beats(base + 2, 20, "t4_wait1");
    repeat (4) tick();
    check("t4_gap_v", 32'(m_valid), 32'd0);
    check("t4_gap_busy", 32'(busy), 32'd1);
    check("t4_gap_n", 32'(beat_q.size() - base), 32'd2);
    push(12'hD03); push(12'hD04); push(12'hD05);
    wait_beats(base + 5, 20, "t4_wait2");
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      check_beat($sformatf("t4_b%0d", i), base + i, {(i == 4), 12'hD01 + 12'(i)});
    end
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_cnt", 32'(frame_cnt), 32'd5);

    // Reset during beat 2 of a 200-beat frame; FIFO read side is flushed too.
    flush_on_rst = 1'b1;
    base = beat_q.size();
    push(12'h0C8);
    for (int i = 0; i < 200; i++) push(12'h100 + 12'(i));
    wait_beats(base + 1, 20, "t5_wait1");
    @(posedge rd_clk); #1;
    check("t5_pre_d", 32'(m_data), 32'h 101);
    rd_rst_n = 1'b0;
    #1;
    check("t5_ren", 32'(fifo_r_en), 32'd0);
    check("t5_valid", 32'(m_valid), 32'd0);
    check("t5_last", 32'(m_last), 32'd0);
    check("t5_data", 32'(m_data), 32'd0);
    check("t5_done", 32'(frame_done), 32'd0);
    check("t5_zl", 32'(zero_len), 32'd0);
    check("t5_cnt", 32'(frame_cnt), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    @(posedge rd_clk); #1;
    rd_rst_n = 1'b1;
    push(12'h002); push(12'hF01); push(12'hF02);
    wait_beats(base + 3, 20, "t5_wait2");
    repeat (3) tick();
    check("t5_nbeats", 32'(beat_q.size() - base), 32'd3);
    check_beat("t5_b0", base + 1, {1'b0, 12'hF01});
    check_beat("t5_b1", base + 2, {1'b1, 12'hF02});
    check("t5_cnt_after", 32'(frame_cnt), 32'd1);

    // Back-to-back single-beat frames until frame_cnt wraps.
    base = beat_q.size(); d0 = done_cnt;
    for (int i = 0; i < 254; i++) begin
      push(12'h001);
      push(12'(i));
    end
    wait_beats(base + 254, 1200, "t6_wait1");
    repeat (3) tick();
    check("t6_cnt_max", 32'(frame_cnt), 32'h FF);
    check("t6_dones1", 32'(done_cnt - d0), 32'd254);
    push(12'h001); push(12'h3C5);
    wait_beats(base + 255, 20, "t6_wait2");
    repeat (3) tick();
    check("t6_cnt_wrap", 32'(frame_cnt), 32'd0);
    check("t6_dones2", 32'(done_cnt - d0), 32'd255);
    check_beat("t6_first", base, {1'b1, 12'h000});
    check_beat("t6_lastbeat", base + 254, {1'b1, 12'h3C5});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
